// File: rtl/count_display_pkg.sv
// ----------------------------------------------------------------------------
// count_display_pkg
// Purpose : Shared types and constants for the count display driver.
//           Scan state enum, active-low 7-segment codes and anode patterns.
// Ports   : none (package)
// Config  : LEADING_ZERO_BLANK_EN (used by count_display_driver)
// ----------------------------------------------------------------------------
package count_display_pkg;

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } scan_state_t;

    // Segment order {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;

    // Anodes, active-low; an[0] = units, an[1] = tens
    localparam logic [3:0] AN_OFF    = 4'hF;
    localparam logic [3:0] AN_UNITS  = 4'b1110;
    localparam logic [3:0] AN_TENS   = 4'b1101;

endpackage

// File: rtl/count_display_driver_if.sv
// ----------------------------------------------------------------------------
// count_display_driver_if
// Purpose : Groups the counter input and the display pin outputs.
// Signals : count[3:0] counter value, an[3:0] anodes (active-low),
//           seg[6:0] segments {g..a} (active-low), dp decimal point.
// Modports: master - the display driver (reads count, drives pins)
//           slave  - the environment (drives count, observes pins)
// Config  : none
// ----------------------------------------------------------------------------
interface count_display_driver_if;
    logic [3:0] count;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (input count, output an, output seg, output dp);
    modport slave  (output count, input an, input seg, input dp);
endinterface

// File: rtl/count_display_driver_seg7_decode.sv
// ----------------------------------------------------------------------------
// seg7_decode
// Purpose : Combinational BCD to active-low 7-segment decoder.
//           Values above 9 decode to a blank digit.
// Ports   : i_bcd [3:0] digit in, o_seg [6:0] segments {g,f,e,d,c,b,a}
// Config  : none
// ----------------------------------------------------------------------------
module seg7_decode
    import count_display_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/count_display_driver.sv
// ----------------------------------------------------------------------------
// count_display_driver
// Purpose : Latches a 4-bit count once per display frame, splits it into
//           decimal tens/units and scans a 4-digit common-anode 7-segment
//           display, blanking all anodes for GHOST_CYCLES at the start of
//           every digit slot.
// Ports   : clk    - system clock, rising edge
//           reset  - synchronous, active-low
//           bus    - count_display_driver_if.master (count in; an, seg, dp out)
// Params  : REFRESH_CYCLES (>= 2) cycles per digit slot
//           GHOST_CYCLES   (1 .. REFRESH_CYCLES-1) blank cycles per slot
// Config  : LEADING_ZERO_BLANK_EN - when defined, the tens digit stays dark
//           for values 0-9; otherwise it shows "0".
// ----------------------------------------------------------------------------
module count_display_driver
    import count_display_pkg::*;
#(
    parameter int REFRESH_CYCLES = 50000,
    parameter int GHOST_CYCLES   = 100
)(
    input  logic                    clk,
    input  logic                    reset,
    count_display_driver_if.master  bus
);

    localparam int             TW          = $clog2(REFRESH_CYCLES);
    localparam logic [TW-1:0]  TIMER_LAST  = TW'(REFRESH_CYCLES - 1);
    localparam logic [TW-1:0]  TIMER_GHOST = TW'(GHOST_CYCLES);

    scan_state_t     r_state;
    scan_state_t     w_state_nxt;
    logic [TW-1:0]   r_timer;
    logic [TW-1:0]   w_timer_nxt;
    logic [3:0]      r_frame_val;
    logic [3:0]      r_an;
    logic [6:0]      r_seg;

    logic            w_load;
    logic            w_tens;
    logic [3:0]      w_units;
    logic [3:0]      w_digit;
    logic [6:0]      w_digit_seg;
    logic [3:0]      w_an_nxt;
    logic [6:0]      w_seg_nxt;

    // Frame latch point: first cycle of DIG0, including the cycle after reset
    assign w_load  = (r_state == DIG0) && (r_timer == '0);

    // Count is at most 15, so a single compare/subtract gives tens/units
    assign w_tens  = (r_frame_val >= 4'd10);
    assign w_units = w_tens ? (r_frame_val - 4'd10) : r_frame_val;

    // One decoder shared across slots; only DIG1 needs the tens digit
    assign w_digit = (r_state == DIG1) ? {3'b000, w_tens} : w_units;

    seg7_decode u_seg7_decode (
        .i_bcd (w_digit),
        .o_seg (w_digit_seg)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= DIG0;
            r_timer     <= '0;
            r_frame_val <= '0;
            r_an        <= AN_OFF;
            r_seg       <= SEG_BLANK;
        end else begin
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            if (w_load) begin
                r_frame_val <= bus.count;
            end
            r_an        <= w_an_nxt;
            r_seg       <= w_seg_nxt;
        end
    end

    // Next state / slot timer
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer + 1'b1;
        if (r_timer >= TIMER_LAST) begin
            w_timer_nxt = '0;
            case (r_state)
                DIG0:    w_state_nxt = DIG1;
                DIG1:    w_state_nxt = DIG2;
                DIG2:    w_state_nxt = DIG3;
                DIG3:    w_state_nxt = DIG0;
                default: w_state_nxt = DIG0;
            endcase
        end else begin
            case (r_state)
                DIG0, DIG1, DIG2, DIG3: w_state_nxt = r_state;
                default:                w_state_nxt = DIG0;
            endcase
        end
    end

    // Next registered pin values, from the current state/timer
    always_comb begin
        w_an_nxt  = AN_OFF;
        w_seg_nxt = SEG_BLANK;
        if (r_timer >= TIMER_GHOST) begin
            case (r_state)
                DIG0: begin
                    w_an_nxt  = AN_UNITS;
                    w_seg_nxt = w_digit_seg;
                end
                DIG1: begin
`ifdef LEADING_ZERO_BLANK_EN
                    if (w_tens) begin
                        w_an_nxt  = AN_TENS;
                        w_seg_nxt = w_digit_seg;
                    end
`else
                    w_an_nxt  = AN_TENS;
                    w_seg_nxt = w_digit_seg;
`endif
                end
                default: begin
                    w_an_nxt  = AN_OFF;
                    w_seg_nxt = SEG_BLANK;
                end
            endcase
        end
    end

    assign bus.an  = r_an;
    assign bus.seg = r_seg;
    assign bus.dp  = 1'b1;

endmodule
